// File: rtl/multicycle_controller_if.sv
// Memory-port handshake between the piRISC control FSM (master) and the single memory port (slave).
interface multicycle_controller_if;
   logic mem_req;
   logic mem_we;
   logic mem_sel;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output mem_sel, input mem_ready);
   modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the piRISC multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WB sequencing.
// Optional memory-access timeout with sticky bus error is enabled by defining MEM_TIMEOUT_EN.
module multicycle_controller #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              opcode,
   input  logic                    branch_taken,
   multicycle_controller_if.master mem,
   output logic                    ir_we,
   output logic                    pc_we,
   output logic [1:0]              pc_sel,
   output logic                    reg_we,
   output logic [1:0]              wb_sel,
   output logic [1:0]              alu_a_sel,
   output logic                    alu_b_sel,
   output logic [1:0]              alu_mode,
   output logic                    illegal,
   output logic                    bus_err,
   output logic [2:0]              state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t     state_r;
   logic       mem_req_r;
   logic       mem_we_r;
   logic       mem_sel_r;
   logic [1:0] a_sel_r;
   logic       b_sel_r;
   logic [1:0] mode_r;
   logic [1:0] wb_sel_r;
   logic [1:0] pc_sel_r;
   logic       is_branch_r;
   logic       is_load_r;
   logic       is_store_r;
   logic       illegal_r;

   logic       dec_legal_s;
   logic [1:0] dec_a_s;
   logic       dec_b_s;
   logic [1:0] dec_mode_s;
   logic [1:0] dec_wb_s;
   logic [1:0] dec_pc_s;
   logic       acc_done_s;
   logic       pc_we_s;
   logic       to_hit_s;

   // Opcode decode into the per-instruction selects latched at the end of DECODE
   always_comb begin
      dec_legal_s = 1'b1;
      dec_a_s     = 2'b00;
      dec_b_s     = 1'b1;
      dec_mode_s  = 2'b00;
      dec_wb_s    = 2'b00;
      dec_pc_s    = 2'b00;
      case (opcode)
         OP_R:      begin dec_b_s = 1'b0; dec_mode_s = 2'b01; end
         OP_I:      dec_mode_s = 2'b01;
         OP_LOAD:   dec_wb_s = 2'b01;
         OP_STORE:  dec_wb_s = 2'b00;
         OP_BRANCH: begin dec_b_s = 1'b0; dec_mode_s = 2'b10; end
         OP_JAL:    begin dec_a_s = 2'b01; dec_wb_s = 2'b10; dec_pc_s = 2'b01; end
         OP_JALR:   begin dec_wb_s = 2'b10; dec_pc_s = 2'b10; end
         OP_LUI:    dec_a_s = 2'b10;
         OP_AUIPC:  dec_a_s = 2'b01;
         default:   dec_legal_s = 1'b0;
      endcase
   end

   // An access completes on a ready seen while a request is outstanding; pc_we marks retirement
   assign acc_done_s = mem_req_r && mem.mem_ready;
   assign pc_we_s    = (state_r == S_WB)
                    || ((state_r == S_EXECUTE) && is_branch_r)
                    || ((state_r == S_MEM) && is_store_r && acc_done_s);

`ifdef MEM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_r;
   logic            bus_err_r;

   // Wait-cycle counter: restarts with every new access, trips when the limit is reached
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_r  <= '0;
         bus_err_r <= 1'b0;
      end else begin
         if (to_hit_s) begin
            bus_err_r <= 1'b1;
         end
         if (!mem_req_r || acc_done_s) begin
            to_cnt_r <= '0;
         end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end
      end
   end

   assign to_hit_s = mem_req_r && !mem.mem_ready && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
   assign bus_err  = bus_err_r;
`else
   assign to_hit_s = 1'b0;
   assign bus_err  = 1'b0;
`endif

   // Control FSM: state sequencing, memory-port handshake and per-instruction select registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_FETCH;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_sel_r   <= 1'b0;
         a_sel_r     <= 2'b00;
         b_sel_r     <= 1'b0;
         mode_r      <= 2'b00;
         wb_sel_r    <= 2'b00;
         pc_sel_r    <= 2'b00;
         is_branch_r <= 1'b0;
         is_load_r   <= 1'b0;
         is_store_r  <= 1'b0;
         illegal_r   <= 1'b0;
      end else begin
         case (state_r)
            S_FETCH: begin
               if (to_hit_s) begin
                  state_r   <= S_TRAP;
                  mem_req_r <= 1'b0;
               end else if (acc_done_s) begin
                  state_r   <= S_DECODE;
                  mem_req_r <= 1'b0;
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            S_DECODE: begin
               if (dec_legal_s) begin
                  state_r     <= S_EXECUTE;
                  a_sel_r     <= dec_a_s;
                  b_sel_r     <= dec_b_s;
                  mode_r      <= dec_mode_s;
                  wb_sel_r    <= dec_wb_s;
                  pc_sel_r    <= dec_pc_s;
                  is_branch_r <= (opcode == OP_BRANCH);
                  is_load_r   <= (opcode == OP_LOAD);
                  is_store_r  <= (opcode == OP_STORE);
               end else begin
                  state_r   <= S_TRAP;
                  illegal_r <= 1'b1;
               end
            end
            S_EXECUTE: begin
               if (is_branch_r) begin
                  state_r   <= S_FETCH;
                  mem_req_r <= 1'b1;
               end else if (is_load_r || is_store_r) begin
                  state_r   <= S_MEM;
                  mem_req_r <= 1'b1;
                  mem_sel_r <= 1'b1;
                  mem_we_r  <= is_store_r;
               end else begin
                  state_r <= S_WB;
               end
            end
            S_MEM: begin
               if (to_hit_s) begin
                  state_r   <= S_TRAP;
                  mem_req_r <= 1'b0;
                  mem_sel_r <= 1'b0;
                  mem_we_r  <= 1'b0;
               end else if (acc_done_s) begin
                  // A store retires here and starts the next fetch without dropping the request
                  state_r   <= is_store_r ? S_FETCH : S_WB;
                  mem_req_r <= is_store_r;
                  mem_sel_r <= 1'b0;
                  mem_we_r  <= 1'b0;
               end
            end
            S_WB: begin
               state_r   <= S_FETCH;
               mem_req_r <= 1'b1;
            end
            S_TRAP: begin
               state_r <= S_TRAP;
            end
            default: begin
               state_r   <= S_TRAP;
               mem_req_r <= 1'b0;
               mem_sel_r <= 1'b0;
               mem_we_r  <= 1'b0;
            end
         endcase
         if (pc_we_s || to_hit_s) begin
            a_sel_r     <= 2'b00;
            b_sel_r     <= 1'b0;
            mode_r      <= 2'b00;
            wb_sel_r    <= 2'b00;
            pc_sel_r    <= 2'b00;
            is_branch_r <= 1'b0;
            is_load_r   <= 1'b0;
            is_store_r  <= 1'b0;
         end
      end
   end

   assign mem.mem_req = mem_req_r;
   assign mem.mem_we  = mem_we_r;
   assign mem.mem_sel = mem_sel_r;
   assign ir_we       = (state_r == S_FETCH) && acc_done_s;
   assign pc_we       = pc_we_s;
   assign pc_sel      = ((state_r == S_EXECUTE) && is_branch_r) ? {1'b0, branch_taken} : pc_sel_r;
   assign reg_we      = (state_r == S_WB);
   assign wb_sel      = wb_sel_r;
   assign alu_a_sel   = a_sel_r;
   assign alu_b_sel   = b_sel_r;
   assign alu_mode    = mode_r;
   assign illegal     = illegal_r;
   assign state_dbg   = state_r;

endmodule
